// File: rtl/keypad_pkg.sv
// keypad_pkg: shared definitions for the 4x4 matrix keypad scanner.
//   - FSM state encoding (SCAN, DEBOUNCE, HELD)
//   - matrix geometry and index widths
//   - first_low_col(): lowest-index active-low column of a column sample
package keypad_pkg;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;
    localparam int ROW_W    = 2;
    localparam int COL_W    = 2;
    localparam int CODE_W   = ROW_W + COL_W;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2
    } kp_state_e;

    // Lowest column index wins when several columns read low.
    function automatic logic [COL_W-1:0] first_low_col(input logic [NUM_COLS-1:0] col_n);
        logic [COL_W-1:0] idx;
        idx = '0;
        for (int i = NUM_COLS - 1; i >= 0; i--) begin
            if (!col_n[i]) idx = COL_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/keypad_tick_gen.sv
// keypad_tick_gen: free-running divider producing a one-cycle tick every DIV clocks.
//   clk    in   system clock
//   rst    in   asynchronous, active-high reset (counter returns to 0)
//   o_tick out  high for one cycle when the counter equals DIV-1
// DIV must be >= 2.
module keypad_tick_gen #(
    parameter int DIV = 50000
) (
    input  logic clk,
    input  logic rst,
    output logic o_tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] r_cnt;

    assign o_tick = (r_cnt == CW'(DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)         r_cnt <= '0;
        else if (o_tick) r_cnt <= '0;
        else             r_cnt <= r_cnt + CW'(1);
    end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl: row-scanning controller for a 4x4 active-low matrix keypad.
// Walks the rows one per scan tick, debounces the column response over
// STABLE_SCANS consecutive tick samples, and reports one code per press.
//   clk       in   system clock
//   rst       in   asynchronous, active-high reset
//   col_n     in   [3:0] keypad columns, active low, asynchronous to clk
//   row_n     out  [3:0] row drive, one-hot-low
//   key_code  out  [3:0] debounced key code = row*4 + col
//   key_valid out  one-cycle pulse per accepted press (and per auto-repeat)
//   key_down  out  high while an accepted key is held
// Build option: define KEYPAD_REPEAT_EN to enable auto-repeat while a key is
// held (first repeat after REPEAT_DELAY ticks, then every REPEAT_RATE ticks).
module keypad_scan_ctrl
    import keypad_pkg::*;
#(
    parameter int TICK_DIV     = 50000,
    parameter int STABLE_SCANS = 4,
    parameter int REPEAT_DELAY = 500,
    parameter int REPEAT_RATE  = 100
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_COLS-1:0] col_n,
    output logic [NUM_ROWS-1:0] row_n,
    output logic [CODE_W-1:0]   key_code,
    output logic                key_valid,
    output logic                key_down
);

    if (TICK_DIV < 2 || STABLE_SCANS < 1 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_param
        $error("keypad_scan_ctrl: illegal parameter value");
    end

    localparam int SCW = $clog2(STABLE_SCANS + 1);

    logic                w_tick;
    logic [NUM_COLS-1:0] r_sync1, r_sync2;
    logic                w_any;
    logic [COL_W-1:0]    w_col;

    kp_state_e        r_state, w_state_nxt;
    logic [ROW_W-1:0] r_row,   w_row_nxt;
    logic [COL_W-1:0] r_cand,  w_cand_nxt;
    logic [SCW-1:0]   r_stab,  w_stab_nxt;
    logic [CODE_W-1:0] r_code, w_code_nxt;
    logic             r_valid, w_valid_nxt;
    logic             r_down,  w_down_nxt;
    logic             w_accept, w_leave;

`ifdef KEYPAD_REPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RW      = $clog2(RPT_MAX + 1);
    logic [RW-1:0] r_rpt, w_rpt_nxt, w_rpt_inc;
    // r_rpt_arm: the first (delayed) repeat has fired; later ones use the rate
    logic          r_rpt_arm, w_rpt_arm_nxt;
`endif

    keypad_tick_gen #(.DIV(TICK_DIV)) u_tick (
        .clk    (clk),
        .rst    (rst),
        .o_tick (w_tick)
    );

    // Two-flop synchronizer; idle (all high) out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
        end else begin
            r_sync1 <= col_n;
            r_sync2 <= r_sync1;
        end
    end

    assign w_any = ~&r_sync2;
    assign w_col = first_low_col(r_sync2);

    always_comb begin
        w_state_nxt = r_state;
        w_row_nxt   = r_row;
        w_cand_nxt  = r_cand;
        w_stab_nxt  = r_stab;
        w_code_nxt  = r_code;
        w_valid_nxt = 1'b0;
        w_down_nxt  = r_down;
        w_accept    = 1'b0;
        w_leave     = 1'b0;
`ifdef KEYPAD_REPEAT_EN
        w_rpt_nxt     = r_rpt;
        w_rpt_arm_nxt = r_rpt_arm;
        w_rpt_inc     = r_rpt + RW'(1);
`endif
        if (w_tick) begin
            case (r_state)
                SCAN: begin
                    if (w_any) begin
                        w_cand_nxt = w_col;
                        if (STABLE_SCANS == 1) begin
                            w_accept = 1'b1;
                        end else begin
                            w_stab_nxt  = SCW'(1);
                            w_state_nxt = DEBOUNCE;
                        end
                    end else begin
                        w_row_nxt = r_row + ROW_W'(1);
                    end
                end
                DEBOUNCE: begin
                    if (w_any && w_col == r_cand) begin
                        if (r_stab + SCW'(1) == SCW'(STABLE_SCANS)) w_accept = 1'b1;
                        else w_stab_nxt = r_stab + SCW'(1);
                    end else begin
                        w_leave = 1'b1;
                    end
                end
                HELD: begin
                    if (!w_any) begin
`ifdef KEYPAD_REPEAT_EN
                        w_rpt_nxt     = '0;
                        w_rpt_arm_nxt = 1'b0;
`endif
                        if (r_stab + SCW'(1) == SCW'(STABLE_SCANS)) begin
                            w_down_nxt = 1'b0;
                            w_leave    = 1'b1;
                        end else begin
                            w_stab_nxt = r_stab + SCW'(1);
                        end
                    end else begin
                        // Any column low restarts the release count, even a
                        // different column: the held key owns the scanner.
                        w_stab_nxt = '0;
`ifdef KEYPAD_REPEAT_EN
                        if (w_rpt_inc == (r_rpt_arm ? RW'(REPEAT_RATE) : RW'(REPEAT_DELAY))) begin
                            w_valid_nxt   = 1'b1;
                            w_rpt_nxt     = '0;
                            w_rpt_arm_nxt = 1'b1;
                        end else begin
                            w_rpt_nxt = w_rpt_inc;
                        end
`endif
                    end
                end
                default: w_state_nxt = SCAN;
            endcase
        end

        // In DEBOUNCE the winning column equals cand, so w_col is valid here.
        if (w_accept) begin
            w_code_nxt  = {r_row, w_col};
            w_valid_nxt = 1'b1;
            w_down_nxt  = 1'b1;
            w_stab_nxt  = '0;
            w_state_nxt = HELD;
`ifdef KEYPAD_REPEAT_EN
            w_rpt_nxt     = '0;
            w_rpt_arm_nxt = 1'b0;
`endif
        end

        if (w_leave) begin
            w_stab_nxt  = '0;
            w_row_nxt   = r_row + ROW_W'(1);
            w_state_nxt = SCAN;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= SCAN;
            r_row   <= '0;
            r_cand  <= '0;
            r_stab  <= '0;
            r_code  <= '0;
            r_valid <= 1'b0;
            r_down  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            r_rpt     <= '0;
            r_rpt_arm <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_row   <= w_row_nxt;
            r_cand  <= w_cand_nxt;
            r_stab  <= w_stab_nxt;
            r_code  <= w_code_nxt;
            r_valid <= w_valid_nxt;
            r_down  <= w_down_nxt;
`ifdef KEYPAD_REPEAT_EN
            r_rpt     <= w_rpt_nxt;
            r_rpt_arm <= w_rpt_arm_nxt;
`endif
        end
    end

    // r_row only moves on the edge closing a tick cycle, so row_n changes on
    // the cycle after the tick and settles for a full period before sampling.
    assign row_n     = ~(NUM_ROWS'(1) << r_row);
    assign key_code  = r_code;
    assign key_valid = r_valid;
    assign key_down  = r_down;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// tb_keypad_scan_ctrl: self-checking bench for keypad_scan_ctrl
// (TICK_DIV=4, STABLE_SCANS=3, REPEAT_DELAY=5, REPEAT_RATE=2).
// The bench plays the keypad: col_n is derived from row_n and a matrix of
// pressed contacts. A tick-level reference model predicts every output on
// every cycle; table vectors and hand sequences add end-to-end checks.
module tb_keypad_scan_ctrl;

    localparam int TD = 4;
    localparam int SS = 3;
    localparam int RD = 5;
    localparam int RR = 2;
`ifdef KEYPAD_REPEAT_EN
    localparam bit REP_EN = 1'b1;
`else
    localparam bit REP_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  col_n, row_n, key_code;
    logic        key_valid, key_down;
    logic [15:0] keys = '0;   // bit r*4+c = contact at row r, column c closed

    always #5 clk = ~clk;

    function automatic logic [3:0] pad(input logic [3:0] rn, input logic [15:0] k);
        logic [3:0] c;
        c = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int cc = 0; cc < 4; cc++)
                if (!rn[r] && k[r*4+cc]) c[cc] = 1'b0;
        return c;
    endfunction

    assign col_n = pad(row_n, keys);

    keypad_scan_ctrl #(
        .TICK_DIV(TD), .STABLE_SCANS(SS), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
    ) dut (
        .clk(clk), .rst(rst), .col_n(col_n), .row_n(row_n),
        .key_code(key_code), .key_valid(key_valid), .key_down(key_down)
    );

    int n_chk = 0;
    int n_fail = 0;
    int pulses;
    int ph;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (one call per scan tick) ----------------
    // phase: 0 idle scanning, 1 confirming a candidate, 2 key owned
    int m_row, m_phase, m_cand, m_streak, m_code, m_down, m_held;
    bit m_valid;

    task automatic model_reset();
        m_row = 0; m_phase = 0; m_cand = 0; m_streak = 0;
        m_code = 0; m_down = 0; m_held = 0; m_valid = 1'b0;
    endtask

    task automatic model_accept();
        m_code = m_row * 4 + m_cand;
        m_valid = 1'b1; m_down = 1; m_streak = 0; m_phase = 2; m_held = 0;
    endtask

    task automatic model_tick(input logic [3:0] c);
        int w;
        w = -1;
        for (int i = 3; i >= 0; i--) if (!c[i]) w = i;
        m_valid = 1'b0;
        if (m_phase == 0) begin
            if (w < 0) m_row = (m_row + 1) % 4;
            else begin
                m_cand = w; m_streak = 1; m_phase = 1;
                if (m_streak >= SS) model_accept();
            end
        end else if (m_phase == 1) begin
            if (w == m_cand) begin
                m_streak++;
                if (m_streak >= SS) model_accept();
            end else begin
                m_phase = 0; m_streak = 0; m_row = (m_row + 1) % 4;
            end
        end else begin
            if (w < 0) begin
                m_streak++; m_held = 0;
                if (m_streak >= SS) begin
                    m_down = 0; m_phase = 0; m_streak = 0; m_row = (m_row + 1) % 4;
                end
            end else begin
                m_streak = 0;
                m_held++;
                if (REP_EN && m_held >= RD && (m_held - RD) % RR == 0) m_valid = 1'b1;
            end
        end
    endtask

    // One clock: advance the model on tick edges, then compare all outputs.
    task automatic step();
        logic [3:0] rn;
        @(posedge clk);
        rn = ~(4'b0001 << m_row);
        if (ph == TD - 1) model_tick(pad(rn, keys));
        else m_valid = 1'b0;
        ph = (ph + 1) % TD;
        #1;
        rn = ~(4'b0001 << m_row);
        check("row_n",     {28'd0, row_n},     {28'd0, rn});
        check("key_valid", {31'd0, key_valid}, {31'd0, m_valid});
        check("key_code",  {28'd0, key_code},  m_code);
        check("key_down",  {31'd0, key_down},  m_down);
        if (key_valid === 1'b1) pulses++;
    endtask

    task automatic ticks(input int n);
        repeat (n * TD) step();
    endtask

    // Asserted on a falling edge; outputs must clear before any rising edge.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_row_n",     {28'd0, row_n},     32'hE);
        check("rst_key_code",  {28'd0, key_code},  32'h0);
        check("rst_key_valid", {31'd0, key_valid}, 32'h0);
        check("rst_key_down",  {31'd0, key_down},  32'h0);
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        ph = 0;
    endtask

    typedef struct {
        logic [15:0] keys;
        int          hold;
        int          exp_pulses;
        logic [3:0]  exp_code;
    } vec_t;

    vec_t tbl[7];
    logic [3:0] rot[5];

    initial begin
        // {contacts, ticks held from reset, expected pulses, expected code}
        tbl[0] = '{16'h0001, 3, 1, 4'h0};   // r0c0, accepted on tick 3
        tbl[1] = '{16'h0200, 5, 1, 4'h9};   // r2c1
        tbl[2] = '{16'h0040, 3, 0, 4'h0};   // r1c2 one tick short
        tbl[3] = '{16'hA000, 6, 1, 4'hD};   // r3 c1+c3, lowest column wins
        tbl[4] = '{16'h8000, 7, 1, 4'hF};   // r3c3
        tbl[5] = '{16'h0810, 6, 1, 4'h4};   // r1c0 seen before r2c3
        tbl[6] = '{16'h0000, 8, 0, 4'h0};   // idle
        rot[0] = 4'b1101; rot[1] = 4'b1011; rot[2] = 4'b0111;
        rot[3] = 4'b1110; rot[4] = 4'b1101;
        pulses = 0;
        ph = 0;
        model_reset();

        // 1: reset mid-count, then idle row rotation
        do_reset();
        ticks(2); step(); step();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            ticks(1);
            check("rotate_row_n", {28'd0, row_n}, {28'd0, rot[i]});
        end

        // table vectors
        for (int i = 0; i < 7; i++) begin
            do_reset();
            keys = tbl[i].keys;
            pulses = 0;
            ticks(tbl[i].hold);
            keys = '0;
            ticks(12);
            check("tbl_pulses",   pulses, tbl[i].exp_pulses);
            check("tbl_key_code", {28'd0, key_code}, {28'd0, tbl[i].exp_code});
            check("tbl_key_down", {31'd0, key_down}, 32'd0);
        end

        // 2: r2c1 held, release needs 3 clean ticks
        do_reset();
        keys = 16'h0200; pulses = 0;
        ticks(5);
        check("hold_down", {31'd0, key_down}, 32'd1);
        check("hold_code", {28'd0, key_code}, 32'h9);
        ticks(2);
        keys = '0;
        ticks(2);
        check("release_down_2", {31'd0, key_down}, 32'd1);
        ticks(1);
        check("release_down_3", {31'd0, key_down}, 32'd0);
        check("hold_pulses", pulses, 32'd1);

        // 3: bounce on r1c2 for 2 ticks
        do_reset();
        keys = 16'h0040; pulses = 0;
        ticks(3);
        keys = '0;
        ticks(1);
        check("bounce_row_n", {28'd0, row_n}, 32'hB);
        check("bounce_pulses", pulses, 32'd0);

        // 5: reset while confirming (streak 2), key still down afterwards
        do_reset();
        keys = 16'h0001;
        ticks(2);
        pulses = 0;
        do_reset();
        ticks(2);
        keys = '0;
        ticks(6);
        check("rst_deb_pulses", pulses, 32'd0);
        check("rst_deb_down", {31'd0, key_down}, 32'd0);

        // 6: key 0 held 12 ticks after accept (repeats when enabled)
        do_reset();
        keys = 16'h0001; pulses = 0;
        ticks(3);
        ticks(12);
        check("repeat_pulses", pulses, REP_EN ? 32'd5 : 32'd1);
        keys = '0;
        ticks(4);
        check("repeat_down", {31'd0, key_down}, 32'd0);

        // randomized contacts, model-checked on every cycle
        do_reset();
        for (int t = 0; t < 400; t++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r < 5) keys = keys;
            else if (r < 7) keys = '0;
            else if (r < 9) keys = 16'(1) << $urandom_range(0, 15);
            else keys = 16'($urandom & $urandom);
            ticks(1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
